// File: rtl/triangle_pkg.sv
// Shared types and default coordinate widths for the triangle dispatch path.
package triangle_pkg;

    localparam int unsigned TRI_WI = 8;
    localparam int unsigned TRI_WF = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from rr_ptr; the pointer
// moves past the granted requester only when the grant is actually used.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // First pass covers rr_ptr..NREQ-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= 32'(rr_ptr))) begin
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr <= '0;
        end else if (en) begin
            rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/triangle_dispatch_ctrl.sv
// Arbitrates producers onto the triangle FIFO write port and drains the FIFO
// (one-cycle read latency) into a registered valid/ready stream.
module triangle_dispatch_ctrl
    import triangle_pkg::*;
#(
    parameter int unsigned WI   = TRI_WI,
    parameter int unsigned WF   = TRI_WF,
    parameter int unsigned NREQ = 2,
    parameter int unsigned CW   = 16
) (
    input  logic                                    Clk,
    input  logic                                    Reset,
    input  logic [NREQ-1:0]                         req_valid,
    input  logic [NREQ-1:0][2:0][2:0][WI+WF-1:0]    req_tri,
    output logic [NREQ-1:0]                         req_ready,
    output logic                                    fifo_w_en,
    output logic [2:0][2:0][WI+WF-1:0]              fifo_tri_in,
    input  logic                                    fifo_full,
    output logic                                    fifo_r_en,
    input  logic [2:0][2:0][WI+WF-1:0]              fifo_tri_out,
    input  logic                                    fifo_empty,
    output logic                                    out_valid,
    output logic [2:0][2:0][WI+WF-1:0]              out_tri,
    input  logic                                    out_ready,
    output logic [CW-1:0]                           in_count,
    output logic [CW-1:0]                           out_count
);

    logic [NREQ-1:0] gnt;
    rd_state_e       state_q, state_d;

    assign fifo_w_en = (|req_valid) & ~fifo_full & ~Reset;
    assign req_ready = gnt & {NREQ{fifo_w_en}};

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .Clk   (Clk),
        .Reset (Reset),
        .req   (req_valid),
        .en    (fifo_w_en),
        .gnt   (gnt)
    );

    // AND-OR mux on the one-hot grant; yields zero when nothing is granted.
    always_comb begin
        fifo_tri_in = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                fifo_tri_in = fifo_tri_in | req_tri[i];
            end
        end
    end

    assign out_valid = (state_q == PRESENT);

    always_comb begin
        state_d   = state_q;
        fifo_r_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_r_en = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_r_en = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (Reset) begin
            fifo_r_en = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            out_tri   <= '0;
            in_count  <= '0;
            out_count <= '0;
        end else begin
            state_q <= state_d;
            // RAM data is valid the cycle after the read strobe.
            if (state_q == FETCH) begin
                out_tri <= fifo_tri_out;
            end
            if (fifo_w_en) begin
                in_count <= in_count + 1'b1;
            end
            if (out_valid && out_ready) begin
                out_count <= out_count + 1'b1;
            end
        end
    end

endmodule
